alu_long_sequencer: RTL and testbench

- Operand sequencer directly upstream and downstream of the 16-bit Alu.
- Accepts word (16-bit) or long (32-bit) ADD/SUB/AND/OR/XOR requests.
- Drives the Alu once for word ops; for long ops drives it twice, low half then high half, chaining carry/borrow between passes.
- Merges per-pass flags into 68000-style XNZVC and returns a registered 32-bit result with a done pulse.

---
 rtl/v68k_alu_pkg.sv | 21 ++
 rtl/alu_flag_merge.sv | 34 +++
 rtl/alu_long_sequencer.sv | 152 +++++++++++++++
 tb/tb_alu_long_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/v68k_alu_pkg.sv
// Shared definitions for the 68000-style Alu and its long-word operand sequencer.
package v68k_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_flag_merge.sv
// Combinational merge of per-pass Alu flags into XNZVC.
module alu_flag_merge
    import v68k_alu_pkg::*;
(
    input  logic [2:0] op,
    input  logic       long_op,
    input  logic       extend,
    input  logic       x_in,
    input  logic       z_in,
    input  logic       z_lo,
    input  logic       alu_c,
    input  logic       alu_z,
    input  logic       alu_v,
    input  logic       alu_n,
    output logic       x,
    output logic       n,
    output logic       z,
    output logic       v,
    output logic       c
);

    logic arith;
    logic z_raw;

    assign arith = is_arith(op);
    assign c     = arith & alu_c;
    assign v     = arith & alu_v;
    assign n     = alu_n;
    assign z_raw = long_op ? (z_lo & alu_z) : alu_z;
    // Extended ops keep Z sticky so a multi-word chain reports zero only if every word was zero.
    assign z     = extend ? (z_raw & z_in) : z_raw;
    assign x     = arith ? alu_c : x_in;

endmodule

// File: rtl/alu_long_sequencer.sv
// Drives the 16-bit Alu once (word) or twice (long, low then high) and returns a merged result.
module alu_long_sequencer
    import v68k_alu_pkg::*;
#(
    parameter int HALF = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              ready,
    input  logic [2:0]        op,
    input  logic              long_op,
    input  logic              extend,
    input  logic [2*HALF-1:0] a,
    input  logic [2*HALF-1:0] b,
    input  logic              x_in,
    input  logic              z_in,
    output logic [HALF-1:0]   alu_a,
    output logic [HALF-1:0]   alu_b,
    output logic [2:0]        alu_op,
    output logic              alu_x,
    input  logic [HALF-1:0]   alu_o,
    input  logic              alu_c,
    input  logic              alu_z,
    input  logic              alu_v,
    input  logic              alu_n,
    output logic [2*HALF-1:0] result,
    output logic              done,
    output logic              x_out,
    output logic              n_out,
    output logic              z_out,
    output logic              v_out,
    output logic              c_out
);

    seq_state_t        state;
    logic [2:0]        op_q;
    logic              long_q;
    logic              ext_q;
    logic              x_q;
    logic              z_q;
    logic [2*HALF-1:0] a_q;
    logic [2*HALF-1:0] b_q;
    logic [HALF-1:0]   res_lo;
    logic              c_lo;
    logic              z_lo;
    logic              m_x, m_n, m_z, m_v, m_c;

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = op_q;
        alu_x  = 1'b0;
        case (state)
            ST_LO: begin
                alu_a = a_q[HALF-1:0];
                alu_b = b_q[HALF-1:0];
                alu_x = is_arith(op_q) & ext_q & x_q;
            end
            ST_HI: begin
                alu_a = a_q[2*HALF-1:HALF];
                alu_b = b_q[2*HALF-1:HALF];
                alu_x = is_arith(op_q) & c_lo;
            end
            default: ;
        endcase
    end

    alu_flag_merge u_merge (
        .op      (op_q),
        .long_op (long_q),
        .extend  (ext_q),
        .x_in    (x_q),
        .z_in    (z_q),
        .z_lo    (z_lo),
        .alu_c   (alu_c),
        .alu_z   (alu_z),
        .alu_v   (alu_v),
        .alu_n   (alu_n),
        .x       (m_x),
        .n       (m_n),
        .z       (m_z),
        .v       (m_v),
        .c       (m_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            result <= '0;
            {x_out, n_out, z_out, v_out, c_out} <= '0;
            op_q   <= '0;
            long_q <= 1'b0;
            ext_q  <= 1'b0;
            x_q    <= 1'b0;
            z_q    <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            res_lo <= '0;
            c_lo   <= 1'b0;
            z_lo   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start && ready) begin
                        op_q   <= op;
                        long_q <= long_op;
                        ext_q  <= extend;
                        x_q    <= x_in;
                        z_q    <= z_in;
                        a_q    <= a;
                        b_q    <= b;
                        state  <= ST_LO;
                        ready  <= 1'b0;
                    end else begin
                        state  <= ST_IDLE;
                        ready  <= 1'b1;
                    end
                end
                ST_LO: begin
                    res_lo <= alu_o;
                    c_lo   <= alu_c;
                    z_lo   <= alu_z;
                    if (long_q) begin
                        state <= ST_HI;
                    end else begin
                        state  <= ST_DONE;
                        ready  <= 1'b1;
                        done   <= 1'b1;
                        result <= {{HALF{1'b0}}, alu_o};
                        {x_out, n_out, z_out, v_out, c_out} <= {m_x, m_n, m_z, m_v, m_c};
                    end
                end
                ST_HI: begin
                    state  <= ST_DONE;
                    ready  <= 1'b1;
                    done   <= 1'b1;
                    result <= {alu_o, res_lo};
                    {x_out, n_out, z_out, v_out, c_out} <= {m_x, m_n, m_z, m_v, m_c};
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_long_sequencer.sv
// Directed bench for alu_long_sequencer with a behavioural 16-bit Alu in the loop.
module tb_alu_long_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ready;
    logic [2:0]  op;
    logic        long_op;
    logic        extend;
    logic [31:0] a, b;
    logic        x_in, z_in;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_x;
    logic [15:0] alu_o;
    logic        alu_c, alu_z, alu_v, alu_n;
    logic [31:0] result;
    logic        done;
    logic        x_out, n_out, z_out, v_out, c_out;

    int vectors = 0;
    int miscompares = 0;
    logic hi_alu_x;

    always #5 clk = ~clk;

    alu_long_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready),
        .op(op), .long_op(long_op), .extend(extend), .a(a), .b(b),
        .x_in(x_in), .z_in(z_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_x(alu_x),
        .alu_o(alu_o), .alu_c(alu_c), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
        .result(result), .done(done),
        .x_out(x_out), .n_out(n_out), .z_out(z_out), .v_out(v_out), .c_out(c_out)
    );

    // Behavioural Alu: SUB computes a - b - x with c as borrow.
    logic [16:0] sum;
    always_comb begin
        sum   = '0;
        alu_o = alu_a;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_op)
            3'b000: begin
                sum   = {1'b0, alu_a} + {1'b0, alu_b} + {16'b0, alu_x};
                alu_o = sum[15:0];
                alu_c = sum[16];
                alu_v = (alu_a[15] == alu_b[15]) && (alu_o[15] != alu_a[15]);
            end
            3'b001: begin
                sum   = {1'b0, alu_a} - {1'b0, alu_b} - {16'b0, alu_x};
                alu_o = sum[15:0];
                alu_c = sum[16];
                alu_v = (alu_a[15] != alu_b[15]) && (alu_o[15] != alu_a[15]);
            end
            3'b010:  alu_o = alu_a & alu_b;
            3'b011:  alu_o = alu_a | alu_b;
            3'b100:  alu_o = alu_a ^ alu_b;
            default: alu_o = alu_a;
        endcase
        alu_z = (alu_o == 16'h0000);
        alu_n = alu_o[15];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic [2:0] o, input logic l, input logic e,
                         input logic [31:0] va, input logic [31:0] vb,
                         input logic x, input logic z);
        op = o; long_op = l; extend = e; a = va; b = vb; x_in = x; z_in = z;
    endtask

    // Issue one request from an idle block and wait (bounded) for done.
    // Flags compared as {X,N,Z,V,C}.
    task automatic run_op(input string tag, input logic [2:0] o, input logic l, input logic e,
                          input logic [31:0] va, input logic [31:0] vb,
                          input logic x, input logic z,
                          input logic [31:0] exp_res, input logic [4:0] exp_flags,
                          input int exp_lat);
        int lat;
        setup(o, l, e, va, vb, x, z);
        start = 1'b1;
        lat = 0;
        hi_alu_x = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 2) hi_alu_x = alu_x;
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_flags"}, {27'b0, x_out, n_out, z_out, v_out, c_out}, {27'b0, exp_flags});
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        setup(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {27'b0, x_out, n_out, z_out, v_out, c_out}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("w_add", 3'b000, 1'b0, 1'b0, 32'h00007FFF, 32'h00000001, 1'b0, 1'b0,
               32'h00008000, 5'b01010, 2);
        run_op("l_add", 3'b000, 1'b1, 1'b0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0,
               32'h00010000, 5'b00000, 3);
        check("l_add_hi_alu_x", {31'b0, hi_alu_x}, 32'd1);
        run_op("l_sub1", 3'b001, 1'b1, 1'b0, 32'h00010000, 32'h00000001, 1'b0, 1'b0,
               32'h0000FFFF, 5'b00000, 3);
        run_op("l_sub2", 3'b001, 1'b1, 1'b0, 32'h00000000, 32'h00000001, 1'b0, 1'b0,
               32'hFFFFFFFF, 5'b11001, 3);
        run_op("addx_z1", 3'b000, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1,
               32'h00000000, 5'b10101, 3);
        run_op("addx_z0", 3'b000, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0,
               32'h00000000, 5'b10001, 3);
        run_op("l_and", 3'b010, 1'b1, 1'b0, 32'hF0F00000, 32'h0F0FFFFF, 1'b1, 1'b0,
               32'h00000000, 5'b10100, 3);
        run_op("w_or", 3'b011, 1'b0, 1'b0, 32'h12340F00, 32'hABCD00F0, 1'b0, 1'b0,
               32'h00000FF0, 5'b00000, 2);
        run_op("w_rsvd", 3'b101, 1'b0, 1'b0, 32'h00008001, 32'h00001234, 1'b1, 1'b0,
               32'h00008001, 5'b11000, 2);
        run_op("w_subx", 3'b001, 1'b0, 1'b1, 32'h00000005, 32'h00000003, 1'b1, 1'b1,
               32'h00000001, 5'b00000, 2);
        run_op("l_xor", 3'b100, 1'b1, 1'b0, 32'h8000FFFF, 32'h0000FFFF, 1'b0, 1'b0,
               32'h80000000, 5'b01000, 3);

        // start pulsed during LO must not disturb the op in flight
        setup(3'b000, 1'b1, 1'b0, 32'h00010002, 32'h00020003, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        check("lo_ready", {31'b0, ready}, 32'd0);
        setup(3'b001, 1'b0, 1'b0, 32'h11111111, 32'h22222222, 1'b1, 1'b1);
        @(negedge clk);
        start = 1'b0;
        check("hi_ready", {31'b0, ready}, 32'd0);
        check("hi_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        check("ign_done", {31'b0, done}, 32'd1);
        check("ign_res", result, 32'h00030005);
        @(negedge clk);
        check("ign_idle_done", {31'b0, done}, 32'd0);

        // reset while in HI
        setup(3'b000, 1'b1, 1'b0, 32'h00050005, 32'h00010001, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rhi_ready", {31'b0, ready}, 32'd1);
        check("rhi_done", {31'b0, done}, 32'd0);
        check("rhi_result", result, 32'd0);
        check("rhi_flags", {27'b0, x_out, n_out, z_out, v_out, c_out}, 32'd0);
        @(negedge clk);
        check("rhi_no_done", {31'b0, done}, 32'd0);

        // start and reset together: reset wins
        setup(3'b000, 1'b0, 1'b0, 32'h1, 32'h1, 1'b0, 1'b0);
        start = 1'b1; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        check("rs_ready", {31'b0, ready}, 32'd1);
        @(negedge clk);
        check("rs_ready2", {31'b0, ready}, 32'd1);
        check("rs_no_done", {31'b0, done}, 32'd0);

        // back-to-back: new start accepted in DONE
        setup(3'b000, 1'b0, 1'b0, 32'h00000010, 32'h00000020, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("b2b_done1", {31'b0, done}, 32'd1);
        check("b2b_ready1", {31'b0, ready}, 32'd1);
        check("b2b_res1", result, 32'h00000030);
        setup(3'b001, 1'b0, 1'b0, 32'h00000010, 32'h00000020, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_lo_ready", {31'b0, ready}, 32'd0);
        check("b2b_lo_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        check("b2b_done2", {31'b0, done}, 32'd1);
        check("b2b_res2", result, 32'h0000FFF0);
        check("b2b_flags2", {27'b0, x_out, n_out, z_out, v_out, c_out}, {27'b0, 5'b11001});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
